// File: rtl/gpio_pkg.sv
// Shared widths and vector types for the gpio input-conditioning slice.
package gpio_pkg;

   localparam int unsigned NumGpio      = 32;
   localparam int unsigned GpioCntWidth = 16;

   typedef logic [NumGpio-1:0]      gpio_vec_t;
   typedef logic [GpioCntWidth-1:0] gpio_cnt_t;

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin two-flop synchroniser followed by an optional saturating debounce counter.
// stable_d_o exposes the next stable level so edge detection lines up with stable_o.
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int unsigned CntWidth = GpioCntWidth
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                pin_i,
   input  logic                en_i,
   input  logic [CntWidth-1:0] limit_i,
   output logic                stable_o,
   output logic                stable_d_o
);

   logic                s1_q, s2_q;
   logic                stable_q, stable_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [CntWidth-1:0] limit_eff;
   logic [CntWidth:0]   cnt_inc;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= pin_i;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // A limit of 0 behaves as 1; the increment is one bit wider so the compare cannot wrap.
   always_comb begin
      limit_eff  = (limit_i == '0) ? CntWidth'(1) : limit_i;
      cnt_inc    = {1'b0, cnt_q} + (CntWidth + 1)'(1);
      stable_d   = stable_q;
      cnt_d      = '0;
      if (!en_i) begin
         stable_d = s2_q;
      end else if (s2_q != stable_q) begin
         if (cnt_inc >= {1'b0, limit_eff}) begin
            stable_d = s2_q;
         end else begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_inc[CntWidth-1:0];
         end
      end
   end

   assign stable_o   = stable_q;
   assign stable_d_o = stable_d;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-pin sync/debounce, edge detect, W1C pending bits and a level
// interrupt that is the OR of all pending bits.
module gpio_in_cond
   import gpio_pkg::*;
#(
   parameter int unsigned NumPins  = NumGpio,
   parameter int unsigned CntWidth = GpioCntWidth
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumPins-1:0]  pin_i,
   input  logic [NumPins-1:0]  db_en_i,
   input  logic [CntWidth-1:0] db_limit_i,
   input  logic [NumPins-1:0]  rise_en_i,
   input  logic [NumPins-1:0]  fall_en_i,
   input  logic [NumPins-1:0]  clear_i,
   output logic [NumPins-1:0]  in_o,
   output logic [NumPins-1:0]  pending_o,
   output logic                intr_o
);

   logic [NumPins-1:0] stable_q, stable_d;
   logic [NumPins-1:0] rise, fall;
   logic [NumPins-1:0] pending_q, pending_d;

   for (genvar i = 0; i < NumPins; i++) begin : gen_pin
      gpio_debounce #(
         .CntWidth (CntWidth)
      ) u_debounce (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .pin_i      (pin_i[i]),
         .en_i       (db_en_i[i]),
         .limit_i    (db_limit_i),
         .stable_o   (stable_q[i]),
         .stable_d_o (stable_d[i])
      );
   end

   // Edges come from the next-state value so pending sets on the same edge in_o changes.
   always_comb begin
      rise      = ~stable_q & stable_d;
      fall      = stable_q & ~stable_d;
      pending_d = (pending_q & ~clear_i) | (rise & rise_en_i) | (fall & fall_en_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign in_o      = stable_q;
   assign pending_o = pending_q;
   assign intr_o    = |pending_q;

endmodule
